// File: rtl/sram_like_bridge_pkg.sv
// ----------------------------------------------------------------------------
// sram_like_bridge_pkg
// Shared constants for the SRAM-port to sram-like bus bridge:
//   - FSM state encodings (2 bits)
//   - bus_size codes
//   - width of the stall bus that stallreq feeds in the pipeline controller
// ----------------------------------------------------------------------------
package sram_like_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // One stall bit per pipeline stage in the controller.
    localparam int STALL_W = 6;

endpackage

// File: rtl/sram_like_bridge_if.sv
// ----------------------------------------------------------------------------
// sram_like_bridge_if
// The sram-like handshake bus.
//   master (bridge) drives: bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
//                           bus_wstrb
//   slave  (bus agent) drives: bus_addr_ok, bus_data_ok, bus_rdata
// Handshake: a request is held stable while bus_req=1 and is accepted on the
// cycle bus_addr_ok=1; the response completes on the cycle bus_data_ok=1,
// with bus_rdata valid only in that cycle. data_ok may coincide with addr_ok.
// ----------------------------------------------------------------------------
interface sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_req;
    logic                  bus_wr;
    logic [1:0]            bus_size;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_like_bridge_wen_to_size.sv
// ----------------------------------------------------------------------------
// wen_to_size
// Combinational decode of core byte enables into bus direction and size.
//   i_cpu_wen  : byte write enables, 0 = read
//   o_bus_wr   : 1 for any nonzero enable pattern
//   o_bus_size : byte for a single enable, half for an aligned enable pair,
//                word for reads, full words and any other pattern
// ----------------------------------------------------------------------------
module wen_to_size
    import sram_like_bridge_pkg::*;
#(
    parameter int STRB_W = 4
) (
    input  logic [STRB_W-1:0] i_cpu_wen,
    output logic              o_bus_wr,
    output logic [1:0]        o_bus_size
);

    logic w_onehot;
    logic w_half;

    always_comb begin
        o_bus_wr = |i_cpu_wen;
        // x & (x-1) clears the lowest set bit; zero result means one bit set.
        w_onehot = (i_cpu_wen != '0) &&
                   ((i_cpu_wen & (i_cpu_wen - STRB_W'(1))) == '0);
        w_half = 1'b0;
        for (int i = 0; i < STRB_W / 2; i++) begin
            if (i_cpu_wen == (STRB_W'(3) << (2 * i))) begin
                w_half = 1'b1;
            end
        end

        if (!o_bus_wr) begin
            o_bus_size = SIZE_W;
        end else if (w_onehot) begin
            o_bus_size = SIZE_B;
        end else if (w_half) begin
            o_bus_size = SIZE_H;
        end else begin
            o_bus_size = SIZE_W;
        end
    end

endmodule

// File: rtl/sram_like_bridge.sv
// ----------------------------------------------------------------------------
// sram_like_bridge
// Converts a fixed-latency SRAM-style core access into a req/addr_ok/data_ok
// transaction and stalls the pipeline until the response returns.
//   clk, rst     : clock, synchronous active-high reset
//   cpu_en       : access request (level, held while stalled)
//   cpu_wen      : byte write enables, 0 = read
//   cpu_addr     : byte address
//   cpu_wdata    : write data
//   cpu_rdata    : buffered read data, stable until the next captured read
//   pipe_hold    : 1 while the consuming stage is not advancing
//   stallreq     : stall request to the pipeline controller
//   dbg_state    : current FSM state
//   bus          : sram-like bus, master side
// ----------------------------------------------------------------------------
module sram_like_bridge
    import sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [DATA_W/8-1:0]   cpu_wen,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  pipe_hold,
    output logic                  stallreq,
    output logic [1:0]            dbg_state,
    sram_like_bridge_if.master    bus
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        r_state;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_rdata;

    logic              w_wr;
    logic [1:0]        w_size;

    wen_to_size #(.STRB_W(STRB_W)) u_wen_to_size (
        .i_cpu_wen  (cpu_wen),
        .o_bus_wr   (w_wr),
        .o_bus_size (w_size)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_en) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wstrb <= cpu_wen;
                        r_wr    <= w_wr;
                        r_size  <= w_size;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_addr_ok) begin
                        // A response arriving with the accept completes at once.
                        if (bus.bus_data_ok) begin
                            if (!r_wr) begin
                                r_rdata <= bus.bus_rdata;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_data_ok) begin
                        if (!r_wr) begin
                            r_rdata <= bus.bus_rdata;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // cpu_en here is the request just served; only the stage
                    // advancing releases the bridge.
                    if (!pipe_hold) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The request latches are only written in IDLE, so they are frozen for
    // the whole time bus_req is high.
    assign bus.bus_req   = (r_state == ST_REQ);
    assign bus.bus_wr    = r_wr;
    assign bus.bus_size  = r_size;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_wstrb = r_wstrb;

    // Stall in the issuing cycle already, so the core holds its request.
    assign stallreq  = ((r_state == ST_IDLE) && cpu_en) ||
                       (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign cpu_rdata = r_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_like_bridge.sv
module tb_sram_like_bridge;
    import sram_like_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        pipe_hold;
    logic        stallreq;
    logic [1:0]  dbg_state;

    sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .pipe_hold (pipe_hold),
        .stallreq  (stallreq),
        .dbg_state (dbg_state),
        .bus       (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;
    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic exp_wr, input logic [1:0] exp_size,
                             input int addr_dly, input int data_dly,
                             input bit same, input int hold);
        int req_cnt;
        if (wen == 4'b0) exp_q.push_back(rdata);
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        pipe_hold = 1'b0;
        #1 check("idle_stall", 32'(stallreq), 32'd1);
        tick();
        check("req_state", 32'(dbg_state), 32'(ST_REQ));
        check("bus_wr", 32'(bus_if.bus_wr), 32'(exp_wr));
        check("bus_size", 32'(bus_if.bus_size), 32'(exp_size));
        check("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(wen));
        check("bus_wdata", bus_if.bus_wdata, wdata);
        req_cnt = 0;
        for (int k = 0; k <= addr_dly; k++) begin
            cpu_addr = k[0] ? ~addr : addr;
            bus_if.bus_addr_ok = (k == addr_dly);
            bus_if.bus_data_ok = same && (k == addr_dly);
            bus_if.bus_rdata = same ? rdata : $urandom;
            #1;
            check("bus_addr_stable", bus_if.bus_addr, addr);
            check("req_stall", 32'(stallreq), 32'd1);
            if (bus_if.bus_req) req_cnt++;
            tick();
        end
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; cpu_addr = addr;
        check("req_cycles", 32'(req_cnt), 32'(addr_dly + 1));
        if (!same) begin
            for (int j = 0; j <= data_dly; j++) begin
                check("wait_state", 32'(dbg_state), 32'(ST_WAIT));
                check("wait_no_req", 32'(bus_if.bus_req), 32'd0);
                bus_if.bus_data_ok = (j == data_dly);
                bus_if.bus_rdata = (j == data_dly) ? rdata : $urandom;
                #1 check("wait_stall", 32'(stallreq), 32'd1);
                tick();
            end
            bus_if.bus_data_ok = 1'b0;
        end
        if (wen == 4'b0) model_rdata = exp_q.pop_front();
        bus_if.bus_rdata = 32'h1234_5678;
        pipe_hold = (hold > 0);
        #1;
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        check("done_stall", 32'(stallreq), 32'd0);
        check("done_rdata", cpu_rdata, model_rdata);
        for (int h = 0; h < hold; h++) begin
            tick();
            pipe_hold = (h + 1 < hold);
            #1;
            check("hold_state", 32'(dbg_state), 32'(ST_DONE));
            check("hold_rdata", cpu_rdata, model_rdata);
            check("hold_no_req", 32'(bus_if.bus_req), 32'd0);
        end
        tick();
        cpu_en = 1'b0;
        #1;
        check("back_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_no_stall", 32'(stallreq), 32'd0);
        check("idle_no_req", 32'(bus_if.bus_req), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_wr;
        logic [1:0]  exp_size;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{4'b0000, 32'hBFC0_0000, 32'h0,         32'h2401_0001, 1'b0, SIZE_W};
        vecs[1]  = '{4'b0100, 32'h8000_0002, 32'h00AB_0000, 32'h0,         1'b1, SIZE_B};
        vecs[2]  = '{4'b0001, 32'h8000_0000, 32'h0000_0011, 32'h0,         1'b1, SIZE_B};
        vecs[3]  = '{4'b0010, 32'h8000_0001, 32'h0000_2200, 32'h0,         1'b1, SIZE_B};
        vecs[4]  = '{4'b1000, 32'h8000_0003, 32'h4400_0000, 32'h0,         1'b1, SIZE_B};
        vecs[5]  = '{4'b0011, 32'h8000_0010, 32'h0000_BEEF, 32'h0,         1'b1, SIZE_H};
        vecs[6]  = '{4'b1100, 32'h8000_0012, 32'hCAFE_0000, 32'h0,         1'b1, SIZE_H};
        vecs[7]  = '{4'b1111, 32'h8000_0020, 32'h0102_0304, 32'h0,         1'b1, SIZE_W};
        vecs[8]  = '{4'b0101, 32'h8000_0031, 32'h00AA_00BB, 32'h0,         1'b1, SIZE_W};
        vecs[9]  = '{4'b0110, 32'h8000_0041, 32'h00CC_DD00, 32'h0,         1'b1, SIZE_W};
        vecs[10] = '{4'b0000, 32'h8000_0105, 32'h0,         32'hA5A5_5A5A, 1'b0, SIZE_W};
        vecs[11] = '{4'b1110, 32'h8000_0051, 32'h1122_3300, 32'h0,         1'b1, SIZE_W};

        n_checks = 0; n_pass = 0; model_rdata = 32'h0;
        rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; pipe_hold = 1'b0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'h0;
        tick(); tick();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_wr", 32'(bus_if.bus_wr), 32'd0);
        check("rst_size", 32'(bus_if.bus_size), 32'd0);
        check("rst_addr", bus_if.bus_addr, 32'h0);
        check("rst_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_stall", 32'(stallreq), 32'd0);
        rst = 1'b0;
        tick();

        // Ideal-bus table: each row is one access with first-chance handshakes.
        for (int v = 0; v < 12; v++) begin
            do_access(vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
                      vecs[v].exp_wr, vecs[v].exp_size, 0, 0, 1'b0, 0);
        end

        // data_ok in IDLE must not touch the buffer.
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h7777_7777;
        tick();
        bus_if.bus_data_ok = 1'b0;
        check("idle_dok_ignored", cpu_rdata, model_rdata);
        check("idle_dok_state", 32'(dbg_state), 32'(ST_IDLE));

        // Slow bus: 6 request cycles, 4 wait cycles, address toggled meanwhile.
        do_access(4'b0000, 32'h9000_0040, 32'h0, 32'h3C1D_8000, 1'b0, SIZE_W, 5, 3, 1'b0, 0);

        // Hold in DONE for 4 cycles while bus_rdata moves.
        do_access(4'b0000, 32'h9000_0080, 32'h0, 32'hDEAD_BEEF, 1'b0, SIZE_W, 0, 0, 1'b0, 4);

        // Same-cycle addr_ok and data_ok.
        do_access(4'b0000, 32'h9000_00C0, 32'h0, 32'h0000_FFFF, 1'b0, SIZE_W, 0, 0, 1'b1, 0);

        // Write after reads leaves the buffer alone.
        do_access(4'b1111, 32'h9000_0100, 32'h5555_AAAA, 32'h0, 1'b1, SIZE_W, 2, 1, 1'b0, 1);

        // Reset while in WAIT.
        cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'h9000_0200;
        tick();
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0;
        check("pre_rst_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b1;
        tick();
        rst = 1'b0; cpu_en = 1'b0;
        model_rdata = 32'h0;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'h0);
        tick();
        do_access(4'b0000, 32'h9000_0204, 32'h0, 32'h0BAD_F00D, 1'b0, SIZE_W, 1, 2, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
